// File: rtl/decade_counter_core.sv
// Free-running modulo-MODULUS (default BCD decade) up-counter with self-correcting illegal states.
// Optional terminal-count output TC is built only when DECADE_COUNTER_TC_EN is defined.
module decade_counter_core #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 10,
    parameter int RESET_VALUE = 0
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef DECADE_COUNTER_TC_EN
    output logic [WIDTH-1:0] Q,
    output logic             TC
`else
    output logic [WIDTH-1:0] Q
`endif
);

    localparam logic [WIDTH-1:0] LAST_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE_VAL   = WIDTH'(1);

    logic [WIDTH-1:0] next_s;

    generate
        if ((MODULUS < 2) || (MODULUS > (1 << WIDTH)) || (RESET_VALUE >= MODULUS) ||
            (RESET_VALUE < 0)) begin : g_cfg_error
            $error("decade_counter_core: illegal WIDTH/MODULUS/RESET_VALUE combination");
        end
    endgenerate

    // Next count: wrap at the last legal value; any out-of-range state also lands on zero.
    always_comb begin
        next_s = {WIDTH{1'b0}};
        if (Q >= LAST_VAL) begin
            next_s = {WIDTH{1'b0}};
        end else begin
            next_s = Q + ONE_VAL;
        end
    end

    // Count register; Q is driven straight from these flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q <= RESET_VAL;
        end else begin
            Q <= next_s;
        end
    end

`ifdef DECADE_COUNTER_TC_EN
    // Terminal count is gated by RST so it stays low for the whole reset pulse.
    assign TC = (~RST) & (Q == LAST_VAL);
`endif

endmodule

// File: tb/tb_decade_counter_core.sv
// Directed self-checking bench for decade_counter_core (default WIDTH=4, MODULUS=10).
// Define DECADE_COUNTER_TC_EN when compiling to also check the TC output.
module tb_decade_counter_core;

    logic       clk;
    logic       rst;
    logic [3:0] q;
`ifdef DECADE_COUNTER_TC_EN
    logic       tc;
`endif

    int checks = 0;
    int errors = 0;

    decade_counter_core #(
        .WIDTH      (4),
        .MODULUS    (10),
        .RESET_VALUE(0)
    ) dut (
        .CLK(clk),
        .RST(rst),
`ifdef DECADE_COUNTER_TC_EN
        .Q  (q),
        .TC (tc)
`else
        .Q  (q)
`endif
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_value(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_tc(input string tag, input int unsigned exp);
`ifdef DECADE_COUNTER_TC_EN
        check_value(tag, 32'(tc), exp);
`endif
    endtask

    initial begin
        int unsigned max_q;
        int unsigned wraps;
        int unsigned prev_q;
        int unsigned exp_q;

        rst = 1'b0;

        // Reset pulse 20..40 ns, rising together with the first clock edge.
        #20 rst = 1'b1;
        #5  check_value("reset_at_coincident_edge", 32'(q), 0);
        check_tc("tc_in_reset", 0);
        #10 check_value("reset_held", 32'(q), 0);
        #5  rst = 1'b0;

        // 250 edges: sequence 1,2,..,9,0,... with exactly 25 wraps.
        max_q  = 0;
        wraps  = 0;
        prev_q = 0;
        for (int i = 0; i < 250; i++) begin
            @(posedge clk);
            #5;
            exp_q = (i + 1) % 10;
            check_value("count", 32'(q), exp_q);
            check_tc("tc_count", (exp_q == 9) ? 1 : 0);
            if (32'(q) > max_q) max_q = 32'(q);
            if ((prev_q == 9) && (q == 4'd0)) wraps++;
            prev_q = 32'(q);
        end
        check_value("max_q", max_q, 9);
        check_value("wrap_count", wraps, 25);

        // Advance 0 -> 6, then an asynchronous reset between edges.
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #5 check_value("pre_async", 32'(q), i);
        end
        #10 rst = 1'b1;
        #2  check_value("async_clear", 32'(q), 0);
        check_tc("tc_async_reset", 0);
        #1  rst = 1'b0;
        @(posedge clk);
        #5 check_value("after_async_release", 32'(q), 1);

        // Reset held across two edges keeps Q at zero.
        for (int i = 2; i <= 9; i++) begin
            @(posedge clk);
        end
        #5 check_value("reach_nine", 32'(q), 9);
        check_tc("tc_at_nine", 1);
        rst = 1'b1;
        #1 check_tc("tc_nine_in_reset", 0);
        @(posedge clk);
        @(posedge clk);
        #5 check_value("reset_held_edges", 32'(q), 0);
        rst = 1'b0;
        @(posedge clk);
        #5 check_value("after_held_release", 32'(q), 1);

        // Illegal state recovery.
        @(negedge clk);
        force dut.Q = 4'd12;
        #1 release dut.Q;
        #1 check_value("forced_illegal", 32'(q), 12);
        check_tc("tc_illegal", 0);
        @(posedge clk);
        #5 check_value("illegal_recover", 32'(q), 0);
        @(posedge clk);
        #5 check_value("illegal_then_one", 32'(q), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
